assoc_cache_ctrl: RTL and testbench

//  Controller FSM for an N-way set-associative, write-back, write-allocate cache in front of a

---
 rtl/assoc_cache_ctrl_pkg.sv | 32 +++
 rtl/assoc_cache_ctrl_victim_sel.sv | 27 ++
 rtl/assoc_cache_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_assoc_cache_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/assoc_cache_ctrl_pkg.sv
// Shared types, encodings and helpers for the N-way set-associative cache controller.
package assoc_cache_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COMP_RD,
        S_COMP_WR,
        S_WB,
        S_WB_DRAIN,
        S_ALLOC,
        S_ALLOC_DRAIN,
        S_INSTALL
    } state_e;

    typedef enum logic [1:0] {
        HC_NONE,
        HC_ONE,
        HC_MULTI
    } hit_class_e;

    localparam int REPL_RR   = 0;
    localparam int REPL_LFSR = 1;
    localparam int LFSR_W    = 8;

    // Classifies a (zero-extended) hit&valid vector as none / exactly one / several.
    function automatic hit_class_e classify_hits(input logic [7:0] v);
        if (v == 8'd0) return HC_NONE;
        if ((v & (v - 8'd1)) == 8'd0) return HC_ONE;
        return HC_MULTI;
    endfunction

endpackage

// File: rtl/assoc_cache_ctrl_victim_sel.sv
// Victim way chooser: lowest-index invalid way wins, otherwise the replacement-policy way.
module assoc_cache_ctrl_victim_sel
    import assoc_cache_ctrl_pkg::*;
#(
    parameter int NUM_WAYS  = 2,
    parameter int REPL_MODE = REPL_RR,
    localparam int WAY_W    = $clog2(NUM_WAYS)
) (
    input  logic [NUM_WAYS-1:0] valid,
    input  logic [WAY_W-1:0]    rr_ptr,
    input  logic [WAY_W-1:0]    lfsr_bits,
    output logic [NUM_WAYS-1:0] victim_oh
);

    logic [WAY_W-1:0] idx;

    always_comb begin
        idx = (REPL_MODE == REPL_LFSR) ? lfsr_bits : rr_ptr;
        // Scanning downwards leaves the lowest invalid way as the final choice.
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (!valid[i]) idx = WAY_W'(i);
        end
        victim_oh      = '0;
        victim_oh[idx] = 1'b1;
    end

endmodule

// File: rtl/assoc_cache_ctrl.sv
// Write-back, write-allocate controller for an N-way cache in front of a pipelined memory.
module assoc_cache_ctrl
    import assoc_cache_ctrl_pkg::*;
#(
    parameter int NUM_WAYS       = 2,
    parameter int WORDS_PER_LINE = 4,
    parameter int MEM_LAT        = 2,
    parameter int REPL_MODE      = REPL_RR,
    localparam int WAY_W         = $clog2(NUM_WAYS),
    localparam int WRD_W         = $clog2(WORDS_PER_LINE)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rd,
    input  logic                wr,
    input  logic [NUM_WAYS-1:0] hit,
    input  logic [NUM_WAYS-1:0] valid,
    input  logic [NUM_WAYS-1:0] dirty,
    output logic [NUM_WAYS-1:0] way_en,
    output logic                comp,
    output logic                write,
    output logic                valid_in,
    output logic                sel_data_cache,
    output logic                rd_mem,
    output logic                wr_mem,
    output logic                sel_tag_mem,
    output logic [WRD_W:0]      mem_offset,
    output logic [WRD_W:0]      cache_offset,
    output logic                done,
    output logic                cache_hit,
    output logic                stall,
    output logic                err
);

    localparam int LAT_W = $clog2(MEM_LAT + 1);
    localparam logic [WRD_W:0]   LAST_WORD  = (WRD_W + 1)'(WORDS_PER_LINE - 1);
    localparam logic [LAT_W-1:0] LAST_DRAIN = LAT_W'(MEM_LAT - 1);

    state_e              state_q, state_d;
    logic [WRD_W:0]      cnt_q, cnt_d;
    logic [WRD_W:0]      fill_q, fill_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic [MEM_LAT-1:0]  pipe_q, pipe_d;
    logic [NUM_WAYS-1:0] victim_q, victim_d, victim_pick;
    logic [WAY_W-1:0]    ptr_q, ptr_d;
    logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
    logic                req_wr_q, req_wr_d;
    logic                miss_seen_q, miss_seen_d;
    logic                fill_act;
    hit_class_e          hc;

    assoc_cache_ctrl_victim_sel #(
        .NUM_WAYS (NUM_WAYS),
        .REPL_MODE(REPL_MODE)
    ) u_victim_sel (
        .valid    (valid),
        .rr_ptr   (ptr_q),
        .lfsr_bits(lfsr_q[WAY_W-1:0]),
        .victim_oh(victim_pick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            fill_q      <= '0;
            lat_q       <= '0;
            pipe_q      <= '0;
            victim_q    <= '0;
            ptr_q       <= '0;
            lfsr_q      <= LFSR_W'(1);
            req_wr_q    <= 1'b0;
            miss_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fill_q      <= fill_d;
            lat_q       <= lat_d;
            pipe_q      <= pipe_d;
            victim_q    <= victim_d;
            ptr_q       <= ptr_d;
            lfsr_q      <= lfsr_d;
            req_wr_q    <= req_wr_d;
            miss_seen_q <= miss_seen_d;
        end
    end

    always_comb begin
        hc          = classify_hits(8'(hit & valid));
        // A read issued MEM_LAT cycles ago has its data at the cache input now.
        fill_act    = pipe_q[MEM_LAT-1];
        state_d     = state_q;
        cnt_d       = cnt_q;
        fill_d      = fill_q;
        lat_d       = lat_q;
        victim_d    = victim_q;
        ptr_d       = ptr_q;
        req_wr_d    = req_wr_q;
        miss_seen_d = miss_seen_q;
        lfsr_d      = {lfsr_q[LFSR_W-2:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

        way_en         = victim_q;
        comp           = 1'b0;
        write          = fill_act;
        valid_in       = 1'b0;
        sel_data_cache = fill_act;
        rd_mem         = 1'b0;
        wr_mem         = 1'b0;
        sel_tag_mem    = 1'b0;
        mem_offset     = '0;
        cache_offset   = fill_act ? {fill_q[WRD_W-1:0], 1'b0} : '0;
        done           = 1'b0;
        cache_hit      = 1'b0;
        stall          = 1'b1;
        err            = 1'b0;

        if (fill_act) fill_d = (fill_q == LAST_WORD) ? '0 : fill_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                way_en      = '1;
                stall       = 1'b0;
                miss_seen_d = 1'b0;
                if (rd && wr) begin
                    err = 1'b1;
                end else if (rd) begin
                    state_d  = S_COMP_RD;
                    req_wr_d = 1'b0;
                end else if (wr) begin
                    state_d  = S_COMP_WR;
                    req_wr_d = 1'b1;
                end
            end
            S_COMP_RD, S_COMP_WR: begin
                way_en = '1;
                comp   = 1'b1;
                write  = (state_q == S_COMP_WR);
                cnt_d  = '0;
                case (hc)
                    HC_ONE: begin
                        done      = 1'b1;
                        cache_hit = !miss_seen_q;
                        ptr_d     = ptr_q + 1'b1;
                        state_d   = S_IDLE;
                    end
                    HC_MULTI: begin
                        err     = 1'b1;
                        state_d = S_IDLE;
                    end
                    default: begin
                        victim_d = victim_pick;
                        state_d  = (|(victim_pick & valid & dirty)) ? S_WB : S_ALLOC;
                    end
                endcase
            end
            S_WB: begin
                wr_mem      = 1'b1;
                sel_tag_mem = 1'b1;
                mem_offset  = {cnt_q[WRD_W-1:0], 1'b0};
                if (cnt_q == LAST_WORD) begin
                    cnt_d   = '0;
                    lat_d   = '0;
                    state_d = S_WB_DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WB_DRAIN: begin
                if (lat_q == LAST_DRAIN) begin
                    lat_d   = '0;
                    state_d = S_ALLOC;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            S_ALLOC: begin
                rd_mem     = 1'b1;
                mem_offset = {cnt_q[WRD_W-1:0], 1'b0};
                if (cnt_q == LAST_WORD) begin
                    cnt_d   = '0;
                    state_d = S_ALLOC_DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ALLOC_DRAIN: begin
                if (fill_act && (fill_q == LAST_WORD)) state_d = S_INSTALL;
            end
            S_INSTALL: begin
                write          = 1'b1;
                valid_in       = 1'b1;
                sel_data_cache = 1'b1;
                miss_seen_d    = 1'b1;
                state_d        = req_wr_q ? S_COMP_WR : S_COMP_RD;
            end
            default: state_d = S_IDLE;
        endcase

        pipe_d = MEM_LAT'({pipe_q, rd_mem});
    end

endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// Bench for assoc_cache_ctrl (4 ways, 4-word lines, MEM_LAT 2, round-robin replacement).
module tb_assoc_cache_ctrl;

    localparam int NW  = 4;
    localparam int WPL = 4;
    localparam int LAT = 2;

    localparam int K_HIT   = 0;
    localparam int K_MISS  = 1;
    localparam int K_BOTH  = 2;
    localparam int K_MULTI = 3;

    logic       clk, rst, rd_i, wr_i;
    logic [3:0] hit_i, valid_i, dirty_i;
    logic [3:0] way_en;
    logic       comp, write, valid_in, sel_data_cache, rd_mem, wr_mem, sel_tag_mem;
    logic [2:0] mem_offset, cache_offset;
    logic       done, cache_hit, stall, err;

    int n_checks = 0;
    int n_fail   = 0;
    int model_ptr = 0;

    typedef struct {
        bit         r;
        bit         w;
        logic [3:0] h;
        logic [3:0] v;
        logic [3:0] d;
        int         kind;
        logic [3:0] vic;
        bit         wb;
        string      name;
    } vec_t;

    vec_t tbl[10];

    assoc_cache_ctrl #(
        .NUM_WAYS      (NW),
        .WORDS_PER_LINE(WPL),
        .MEM_LAT       (LAT),
        .REPL_MODE     (0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rd            (rd_i),
        .wr            (wr_i),
        .hit           (hit_i),
        .valid         (valid_i),
        .dirty         (dirty_i),
        .way_en        (way_en),
        .comp          (comp),
        .write         (write),
        .valid_in      (valid_in),
        .sel_data_cache(sel_data_cache),
        .rd_mem        (rd_mem),
        .wr_mem        (wr_mem),
        .sel_tag_mem   (sel_tag_mem),
        .mem_offset    (mem_offset),
        .cache_offset  (cache_offset),
        .done          (done),
        .cache_hit     (cache_hit),
        .stall         (stall),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Transaction-level expectation: outcome class, victim way and whether a write-back is due.
    function automatic void predict(input bit r, input bit w, input logic [3:0] h,
                                    input logic [3:0] v, input logic [3:0] d, input int ptr,
                                    output int kind, output logic [3:0] vic, output bit wb);
        int n;
        int idx;
        logic [3:0] hv;
        hv  = h & v;
        n   = 0;
        vic = 4'h0;
        wb  = 1'b0;
        for (int i = 0; i < NW; i++) if (hv[i]) n++;
        if (r && w) kind = K_BOTH;
        else if (n == 1) kind = K_HIT;
        else if (n > 1) kind = K_MULTI;
        else begin
            kind = K_MISS;
            idx  = -1;
            for (int i = 0; i < NW; i++) if (!v[i] && idx < 0) idx = i;
            if (idx < 0) idx = ptr;
            vic = 4'(1 << idx);
            wb  = v[idx] & d[idx];
        end
    endfunction

    task automatic run_txn(input string tag, input bit r, input bit w, input logic [3:0] h,
                           input logic [3:0] v, input logic [3:0] d, input int kind,
                           input logic [3:0] vic, input bit wb);
        int exp_done, done_at, inst_at, first_rd, first_fill, n_rd, n_wr, n_fill;
        logic hit_at, wr_at;
        exp_done = 1 + (wb ? WPL + LAT : 0) + WPL + LAT + 2;
        done_at = -1; inst_at = -1; first_rd = -1; first_fill = -1;
        n_rd = 0; n_wr = 0; n_fill = 0; hit_at = 1'b1; wr_at = 1'b0;

        @(posedge clk); #1;
        rd_i = r; wr_i = w; hit_i = h; valid_i = v; dirty_i = d;
        #2;
        check({tag, " idle_stall"}, 32'(stall), 0);
        check({tag, " idle_err"}, 32'(err), (kind == K_BOTH) ? 1 : 0);
        @(posedge clk); #1;
        rd_i = 1'b0; wr_i = 1'b0;
        #2;
        if (kind == K_BOTH) begin
            check({tag, " err_stays_idle"}, 32'(stall), 0);
            check({tag, " err_one_cycle"}, 32'(err), 0);
        end else begin
            check({tag, " comp"}, 32'(comp), 1);
            check({tag, " comp_stall"}, 32'(stall), 1);
            check({tag, " comp_write"}, 32'(write), 32'(w));
            check({tag, " comp_way_en"}, 32'(way_en), 32'hF);
            check({tag, " comp_done"}, 32'(done), (kind == K_HIT) ? 1 : 0);
            check({tag, " comp_err"}, 32'(err), (kind == K_MULTI) ? 1 : 0);
            if (kind == K_HIT) check({tag, " cache_hit"}, 32'(cache_hit), 1);
            if (kind == K_MISS) begin
                for (int c = 2; c <= exp_done + 4 && done_at < 0; c++) begin
                    @(posedge clk); #1;
                    if (c == exp_done) begin
                        hit_i = vic; valid_i = v | vic; dirty_i = d & ~vic;
                    end
                    #2;
                    if (wr_mem) begin
                        check({tag, " wb_offset"}, 32'(mem_offset), 2 * n_wr);
                        check({tag, " wb_tag_sel"}, 32'(sel_tag_mem), 1);
                        check({tag, " wb_way_en"}, 32'(way_en), 32'(vic));
                        n_wr++;
                    end
                    if (rd_mem) begin
                        check({tag, " rd_offset"}, 32'(mem_offset), 2 * n_rd);
                        check({tag, " rd_way_en"}, 32'(way_en), 32'(vic));
                        if (first_rd < 0) first_rd = c;
                        n_rd++;
                    end
                    if (sel_data_cache && !valid_in) begin
                        check({tag, " fill_offset"}, 32'(cache_offset), 2 * n_fill);
                        check({tag, " fill_write"}, 32'(write), 1);
                        if (first_fill < 0) first_fill = c;
                        n_fill++;
                    end
                    if (valid_in) begin
                        check({tag, " install_way_en"}, 32'(way_en), 32'(vic));
                        inst_at = c;
                    end
                    if (done) begin
                        done_at = c;
                        hit_at  = cache_hit;
                        wr_at   = write;
                    end
                end
                check({tag, " miss_done_cycle"}, 32'(done_at), 32'(exp_done));
                check({tag, " miss_cache_hit"}, 32'(hit_at), 0);
                check({tag, " replay_write"}, 32'(wr_at), 32'(w));
                check({tag, " install_cycle"}, 32'(inst_at), 32'(exp_done - 1));
                check({tag, " n_wr_mem"}, 32'(n_wr), wb ? WPL : 0);
                check({tag, " n_rd_mem"}, 32'(n_rd), WPL);
                check({tag, " n_fill"}, 32'(n_fill), WPL);
                check({tag, " first_rd"}, 32'(first_rd), 32'(wb ? 2 + WPL + LAT : 2));
                check({tag, " first_fill"}, 32'(first_fill), 32'(first_rd + LAT));
            end
            @(posedge clk); #1;
            hit_i = 4'h0;
            #2;
            check({tag, " back_idle"}, 32'(stall), 0);
        end
        if (kind == K_HIT || kind == K_MISS) model_ptr = (model_ptr + 1) % NW;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit r, w, wb;
        logic [3:0] h, v, d, vic;
        int kind;

        tbl[0] = '{1'b1, 1'b0, 4'b0100, 4'hF,    4'h0,    K_HIT,   4'b0000, 1'b0, "rd_hit_way2"};
        tbl[1] = '{1'b1, 1'b0, 4'b0000, 4'hF,    4'h0,    K_MISS,  4'b0010, 1'b0, "rd_clean_miss_ptr1"};
        tbl[2] = '{1'b0, 1'b1, 4'b0000, 4'hF,    4'hF,    K_MISS,  4'b0100, 1'b1, "wr_dirty_miss_ptr2"};
        tbl[3] = '{1'b1, 1'b0, 4'b0000, 4'b0111, 4'hF,    K_MISS,  4'b1000, 1'b0, "rd_invalid_way3"};
        tbl[4] = '{1'b1, 1'b1, 4'b0000, 4'hF,    4'h0,    K_BOTH,  4'b0000, 1'b0, "rd_and_wr"};
        tbl[5] = '{1'b1, 1'b0, 4'b0011, 4'hF,    4'h0,    K_MULTI, 4'b0000, 1'b0, "multi_hit"};
        tbl[6] = '{1'b0, 1'b1, 4'b0001, 4'hF,    4'h0,    K_HIT,   4'b0000, 1'b0, "wr_hit_way0"};
        tbl[7] = '{1'b1, 1'b0, 4'b1000, 4'b0111, 4'h0,    K_MISS,  4'b1000, 1'b0, "hit_on_invalid"};
        tbl[8] = '{1'b1, 1'b0, 4'b0000, 4'b0101, 4'hF,    K_MISS,  4'b0010, 1'b0, "lowest_invalid_way1"};
        tbl[9] = '{1'b0, 1'b1, 4'b0000, 4'hF,    4'b1000, K_MISS,  4'b1000, 1'b1, "wr_dirty_miss_ptr3"};

        rst = 1'b1; rd_i = 1'b0; wr_i = 1'b0; hit_i = 4'h0; valid_i = 4'h0; dirty_i = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #2;
        check("reset way_en", 32'(way_en), 32'hF);
        check("reset stall", 32'(stall), 0);
        check("reset done", 32'(done), 0);
        check("reset err", 32'(err), 0);
        check("reset comp", 32'(comp), 0);
        check("reset write", 32'(write), 0);
        check("reset rd_mem", 32'(rd_mem), 0);
        check("reset wr_mem", 32'(wr_mem), 0);
        check("reset mem_offset", 32'(mem_offset), 0);
        check("reset cache_offset", 32'(cache_offset), 0);

        for (int i = 0; i < 10; i++) begin
            run_txn(tbl[i].name, tbl[i].r, tbl[i].w, tbl[i].h, tbl[i].v, tbl[i].d,
                    tbl[i].kind, tbl[i].vic, tbl[i].wb);
        end

        // Reset during the second ALLOC cycle must abort the burst and the pending fills.
        @(posedge clk); #1;
        rd_i = 1'b1; hit_i = 4'h0; valid_i = 4'hF; dirty_i = 4'h0;
        @(posedge clk); #1;
        rd_i = 1'b0;
        @(posedge clk); #1; #2;
        check("rst_seq alloc1 rd_mem", 32'(rd_mem), 1);
        @(posedge clk); #1;
        rst = 1'b1;
        #2;
        check("rst_seq alloc2 offset", 32'(mem_offset), 2);
        @(posedge clk); #1;
        rst = 1'b0;
        #2;
        check("rst_seq idle rd_mem", 32'(rd_mem), 0);
        check("rst_seq idle way_en", 32'(way_en), 32'hF);
        check("rst_seq idle stall", 32'(stall), 0);
        check("rst_seq no fill", 32'(sel_data_cache), 0);
        @(posedge clk); #1; #2;
        check("rst_seq no fill later", 32'(write), 0);
        check("rst_seq still idle", 32'(stall), 0);
        model_ptr = 0;

        for (int i = 0; i < 60; i++) begin
            r = 1'($urandom_range(0, 1));
            w = !r;
            if ($urandom_range(0, 9) == 0) begin r = 1'b1; w = 1'b1; end
            v = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            d = 4'($urandom_range(0, 15));
            h = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            predict(r, w, h, v, d, model_ptr, kind, vic, wb);
            run_txn($sformatf("rnd%0d", i), r, w, h, v, d, kind, vic, wb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
